// File: rtl/aes_round_key_sequencer_if.sv
// Round-key handshake bundle between the sequencer and the
// AES round datapath (valid/ready with 128-bit key payload).
interface aes_round_key_sequencer_if #(
  parameter int RN_W = 4
);
  logic            rk_valid;
  logic            rk_ready;
  logic [127:0]    rk_data;
  logic [RN_W-1:0] rk_round;
  logic            rk_last;

  modport master (
    output rk_valid,
    output rk_data,
    output rk_round,
    output rk_last,
    input  rk_ready
  );

  modport slave (
    input  rk_valid,
    input  rk_data,
    input  rk_round,
    input  rk_last,
    output rk_ready
  );
endinterface

// File: rtl/aes_round_key_sequencer.sv
// Walks key_expand's word port, 4 words per round, and streams
// 128-bit round keys in encrypt (0..NR) or decrypt (NR..0) order.
module aes_round_key_sequencer #(
  parameter int NR   = 10,
  parameter int RN_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            key_start,
  input  logic            key_done,
  output logic [RN_W-1:0] ke_round_key_num,
  output logic [1:0]      ke_r_index,
  input  logic [31:0]     ke_round_key,
  input  logic            start,
  input  logic            decrypt,
  aes_round_key_sequencer_if.master rk,
  output logic            busy,
  output logic            err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] PRESENT = 2'd2;

  localparam logic [RN_W-1:0] LAST = RN_W'(NR);
  localparam logic [RN_W-1:0] ONE  = RN_W'(1);
  localparam logic [RN_W-1:0] ZERO = '0;

  logic [1:0]      state;
  logic [1:0]      widx;
  logic            dec;
  logic            lead;
  logic            key_ok;
  logic [RN_W-1:0] nxt;

  assign busy = (state != IDLE);
  assign nxt  = dec ? (rk.rk_round - ONE)
                    : (rk.rk_round + ONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      widx             <= 2'd0;
      dec              <= 1'b0;
      lead             <= 1'b0;
      key_ok           <= 1'b0;
      err              <= 1'b0;
      ke_round_key_num <= '0;
      ke_r_index       <= 2'd0;
      rk.rk_valid      <= 1'b0;
      rk.rk_data       <= '0;
      rk.rk_round      <= '0;
      rk.rk_last       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (key_start)
        key_ok <= 1'b0;
      else if (key_done)
        key_ok <= 1'b1;

      if (key_start) begin
        state            <= IDLE;
        widx             <= 2'd0;
        lead             <= 1'b0;
        ke_round_key_num <= '0;
        ke_r_index       <= 2'd0;
        rk.rk_valid      <= 1'b0;
        rk.rk_last       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            ke_round_key_num <= '0;
            ke_r_index       <= 2'd0;
            if (start && key_ok) begin
              dec              <= decrypt;
              rk.rk_round      <= decrypt ? LAST : ZERO;
              ke_round_key_num <= decrypt ? LAST : ZERO;
              widx             <= 2'd0;
              lead             <= 1'b1;
              state            <= FETCH;
            end else if (start) begin
              err <= 1'b1;
            end
          end
          FETCH: begin
            // First cycle only settles the registered word select
            if (lead) begin
              lead <= 1'b0;
            end else begin
              unique case (widx)
                2'd0: rk.rk_data[127:96] <= ke_round_key;
                2'd1: rk.rk_data[95:64]  <= ke_round_key;
                2'd2: rk.rk_data[63:32]  <= ke_round_key;
                2'd3: rk.rk_data[31:0]   <= ke_round_key;
              endcase
              if (widx == 2'd3) begin
                state       <= PRESENT;
                rk.rk_valid <= 1'b1;
                rk.rk_last  <= dec ? (rk.rk_round == ZERO)
                                   : (rk.rk_round == LAST);
              end else begin
                widx       <= widx + 2'd1;
                ke_r_index <= widx + 2'd1;
              end
            end
          end
          PRESENT: begin
            if (rk.rk_ready) begin
              rk.rk_valid <= 1'b0;
              rk.rk_last  <= 1'b0;
              if (rk.rk_last) begin
                state            <= IDLE;
                ke_round_key_num <= '0;
                ke_r_index       <= 2'd0;
              end else begin
                rk.rk_round      <= nxt;
                ke_round_key_num <= nxt;
                ke_r_index       <= 2'd0;
                widx             <= 2'd0;
                lead             <= 1'b1;
                state            <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_round_key_sequencer.sv
// Bench: AES key-expansion model feeds the word port; expected
// round keys are queued at start and popped on each accept.
module tb_aes_round_key_sequencer;

  localparam int NR = 10;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   round;
    logic         last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_start;
  logic        key_done;
  logic [3:0]  ke_round_key_num;
  logic [1:0]  ke_r_index;
  logic [31:0] ke_round_key;
  logic        start;
  logic        decrypt;
  logic        busy;
  logic        err;

  aes_round_key_sequencer_if #(.RN_W(4)) rk_bus ();

  aes_round_key_sequencer #(.NR(NR), .RN_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .key_start        (key_start),
    .key_done         (key_done),
    .ke_round_key_num (ke_round_key_num),
    .ke_r_index       (ke_r_index),
    .ke_round_key     (ke_round_key),
    .start            (start),
    .decrypt          (decrypt),
    .rk               (rk_bus),
    .busy             (busy),
    .err              (err)
  );

  always #5 clk = ~clk;

  logic [7:0]  sb [0:255];
  logic [31:0] ks [0:1][0:43];
  int          key_sel;
  int          widx_i;
  exp_t        sbq[$];
  int          checks;
  int          errors;
  int          cyc;
  int          ref_cyc;
  bit          vprev;

  localparam logic [127:0] FIPS0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always_comb begin
    widx_i = int'(ke_round_key_num) * 4 + int'(ke_r_index);
    ke_round_key = (widx_i < 44) ? ks[key_sel][widx_i] : 32'h0;
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  task automatic expand(input int s, input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) ks[s][i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = ks[s][i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      ks[s][i] = ks[s][i-4] ^ t;
    end
  endtask

  task automatic push_sched(input bit dec);
    exp_t e;
    int r;
    for (int k = 0; k <= NR; k++) begin
      r = dec ? NR - k : k;
      e.data  = {ks[key_sel][4*r], ks[key_sel][4*r+1],
                 ks[key_sel][4*r+2], ks[key_sel][4*r+3]};
      e.round = 4'(r);
      e.last  = (k == NR);
      sbq.push_back(e);
    end
  endtask

  // Observation point: the falling edge between two active edges
  task automatic sample();
    exp_t e;
    if (reset && rk_bus.rk_valid && !vprev)
      check("latency", 128'(cyc - ref_cyc), 128'd5);
    vprev = reset && rk_bus.rk_valid;
    if (reset && rk_bus.rk_valid && rk_bus.rk_ready) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 128'd0, 128'd1);
      end else begin
        e = sbq.pop_front();
        check("rk_data", rk_bus.rk_data, e.data);
        check("rk_round", 128'(rk_bus.rk_round), 128'(e.round));
        check("rk_last", 128'(rk_bus.rk_last), 128'(e.last));
        if (key_sel == 0 && e.round == 4'd0)
          check("fips_rk0", rk_bus.rk_data, FIPS0);
        if (key_sel == 0 && e.round == 4'd1)
          check("fips_rk1", rk_bus.rk_data, FIPS1);
        if (key_sel == 0 && e.round == 4'd10)
          check("fips_rk10", rk_bus.rk_data, FIPS10);
      end
      ref_cyc = cyc + 1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic start_sched(input bit dec);
    start   = 1'b1;
    decrypt = dec;
    push_sched(dec);
    tick();
    start   = 1'b0;
    ref_cyc = cyc;
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!rk_bus.rk_valid && n < max) begin
      tick();
      n++;
    end
    check("valid_timeout", 128'(rk_bus.rk_valid), 128'd1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check("idle_timeout", 128'(busy), 128'd0);
    check("sb_drained", 128'(sbq.size()), 128'd0);
  endtask

  task automatic start_err();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", 128'(err), 128'd1);
    check("err_busy", 128'(busy), 128'd0);
    check("err_valid", 128'(rk_bus.rk_valid), 128'd0);
    tick();
    check("err_clear", 128'(err), 128'd0);
  endtask

  initial begin
    logic [1:0] idx0;
    int n;
    checks = 0; errors = 0; cyc = 0; ref_cyc = 0; vprev = 1'b0;
    key_sel = 0;
    reset = 1'b0; key_start = 1'b0; key_done = 1'b0;
    start = 1'b0; decrypt = 1'b0; rk_bus.rk_ready = 1'b0;
    build_sbox();
    expand(0, FIPS0);
    expand(1, 128'h000102030405060708090a0b0c0d0e0f);

    repeat (3) tick();
    check("rst_valid", 128'(rk_bus.rk_valid), 128'd0);
    check("rst_data", rk_bus.rk_data, 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_ke", 128'({ke_round_key_num, ke_r_index}), 128'd0);
    reset = 1'b1;
    tick();

    start_err();

    key_done = 1'b1;
    repeat (2) tick();
    rk_bus.rk_ready = 1'b1;
    start_sched(1'b0);
    wait_idle(200);

    start_sched(1'b1);
    wait_idle(200);
    check("data_kept", rk_bus.rk_data, FIPS0);
    check("ke_idle", 128'({ke_round_key_num, ke_r_index}), 128'd0);

    rk_bus.rk_ready = 1'b0;
    start_sched(1'b0);
    for (int k = 0; k <= NR; k++) begin
      wait_valid(20);
      if (rk_bus.rk_round == 4'd1) begin
        idx0  = ke_r_index;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_start_err", 128'(err), 128'd0);
        for (int h = 0; h < 7; h++) begin
          tick();
          check("hold_data", rk_bus.rk_data, FIPS1);
          check("hold_valid", 128'(rk_bus.rk_valid), 128'd1);
          check("hold_idx", 128'(ke_r_index), 128'(idx0));
        end
      end
      rk_bus.rk_ready = 1'b1;
      tick();
      rk_bus.rk_ready = 1'b0;
    end
    wait_idle(20);

    rk_bus.rk_ready = 1'b1;
    start_sched(1'b0);
    n = 0;
    while (!(busy && !rk_bus.rk_valid && rk_bus.rk_round == 4'd3) && n < 100) begin
      tick();
      n++;
    end
    check("reach_r3", 128'(rk_bus.rk_round), 128'd3);
    key_start = 1'b1;
    key_done  = 1'b0;
    key_sel   = 1;
    tick();
    key_start = 1'b0;
    check("abort_busy", 128'(busy), 128'd0);
    check("abort_valid", 128'(rk_bus.rk_valid), 128'd0);
    sbq.delete();
    start_err();
    key_done = 1'b1;
    repeat (2) tick();
    start_sched(1'b0);
    wait_idle(200);

    rk_bus.rk_ready = 1'b0;
    start_sched(1'b0);
    wait_valid(20);
    #3;
    reset = 1'b0;
    #1;
    check("arst_valid", 128'(rk_bus.rk_valid), 128'd0);
    check("arst_data", rk_bus.rk_data, 128'd0);
    check("arst_busy", 128'(busy), 128'd0);
    sbq.delete();
    key_done = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    start_err();
    key_done = 1'b1;
    repeat (2) tick();
    rk_bus.rk_ready = 1'b1;
    start_sched(1'b1);
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
